// File: rtl/alu_pkg.sv
// Shared ALU definitions: datapath width, alu_ctrl encodings and exec-unit FSM states.
// Imported by alu_exec_unit, alu_shifter and the ALU control decoder.
package alu_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned CTRL_W  = 5;
  localparam int unsigned SHAMT_W = 5;

  // alu_ctrl operation codes; any other code executes as ADD
  typedef enum logic [CTRL_W-1:0] {
    AluAnd = 5'b00000,
    AluOr  = 5'b00001,
    AluAdd = 5'b00010,
    AluSub = 5'b00110,
    AluSlt = 5'b00111,
    AluNor = 5'b01100,
    AluXor = 5'b01101,
    AluSll = 5'b10000,
    AluSrl = 5'b10001,
    AluSra = 5'b10010
  } alu_op_e;

  // Execution unit FSM states
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StShift = 2'b01,
    StDone  = 2'b10
  } exec_state_e;

  // True for the three shift operations
  function automatic logic is_shift_op(input logic [CTRL_W-1:0] ctrl);
    return (ctrl == AluSll) || (ctrl == AluSrl) || (ctrl == AluSra);
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Shift datapath for the ALU execution unit.
// With ALU_FAST_SHIFT_EN defined this is a full barrel shifter; otherwise it performs a
// single one-bit step per use, and only when the remaining amount is non-zero.
module alu_shifter
  import alu_pkg::*;
(
  input  logic [CTRL_W-1:0]  i_kind,
  input  logic [DATA_W-1:0]  i_data,
  input  logic [SHAMT_W-1:0] i_amount,
  output logic [DATA_W-1:0]  o_data
);

`ifdef ALU_FAST_SHIFT_EN
  // Shift the full amount in one pass
  always_comb begin
    o_data = i_data;
    case (i_kind)
      AluSll:  o_data = i_data << i_amount;
      AluSrl:  o_data = i_data >> i_amount;
      AluSra:  o_data = $signed(i_data) >>> i_amount;
      default: o_data = i_data;
    endcase
  end
`else
  // One-bit step; a zero amount means nothing is left to shift
  always_comb begin
    o_data = i_data;
    if (i_amount != '0) begin
      case (i_kind)
        AluSll:  o_data = {i_data[DATA_W-2:0], 1'b0};
        AluSrl:  o_data = {1'b0, i_data[DATA_W-1:1]};
        AluSra:  o_data = {i_data[DATA_W-1], i_data[DATA_W-1:1]};
        default: o_data = i_data;
      endcase
    end
  end
`endif

endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit with valid/ready handshakes on both sides and a registered result.
// Non-shift ops complete one cycle after acceptance and may stream back-to-back.
// Config macro ALU_FAST_SHIFT_EN: defined -> single-cycle barrel shifts (SHIFT state unused);
// undefined -> shifts iterate one bit per cycle in the SHIFT state.
module alu_exec_unit
  import alu_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [CTRL_W-1:0]  alu_ctrl,
  input  logic               sign,
  input  logic [DATA_W-1:0]  op_a,
  input  logic [DATA_W-1:0]  op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  result,
  output logic               zero
);

  exec_state_e       r_state;
  exec_state_e       w_state_next;
  logic [DATA_W-1:0] r_result;
  logic [DATA_W-1:0] w_alu_result;
  logic [DATA_W-1:0] w_shift_out;
  logic [DATA_W-1:0] w_shift_load;
  logic              w_accept;
  logic              w_slt;
  logic              w_go_shift;
  logic              w_shift_last;

  assign w_accept = in_valid && in_ready;
  assign w_slt    = sign ? ($signed(op_a) < $signed(op_b)) : (op_a < op_b);

`ifdef ALU_FAST_SHIFT_EN
  // Barrel shift straight from the offered operands
  alu_shifter u_shifter (
    .i_kind   (alu_ctrl),
    .i_data   (op_b),
    .i_amount (shamt),
    .o_data   (w_shift_out)
  );

  assign w_shift_load = w_shift_out;
  assign w_go_shift   = 1'b0;
  assign w_shift_last = 1'b1;
`else
  logic [CTRL_W-1:0]  r_shift_kind;
  logic [SHAMT_W-1:0] r_shift_cnt;
  logic [SHAMT_W-1:0] w_shift_cnt_next;

  // Step the partially shifted value held in the result register
  alu_shifter u_shifter (
    .i_kind   (r_shift_kind),
    .i_data   (r_result),
    .i_amount (r_shift_cnt),
    .o_data   (w_shift_out)
  );

  // Shifts load the unshifted source; a zero amount completes immediately
  assign w_shift_load     = op_b;
  assign w_go_shift       = is_shift_op(alu_ctrl) && (shamt != '0);
  assign w_shift_cnt_next = r_shift_cnt - SHAMT_W'(1);
  assign w_shift_last     = (w_shift_cnt_next == '0);

  // Shift kind and remaining bit count for the op in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shift_kind <= '0;
      r_shift_cnt  <= '0;
    end else if (w_accept) begin
      r_shift_kind <= alu_ctrl;
      r_shift_cnt  <= w_go_shift ? shamt : '0;
    end else if (r_state == StShift) begin
      r_shift_cnt  <= w_shift_cnt_next;
    end
  end
`endif

  // Result of the offered op, registered on acceptance
  always_comb begin
    w_alu_result = op_a + op_b;
    case (alu_ctrl)
      AluAnd:                 w_alu_result = op_a & op_b;
      AluOr:                  w_alu_result = op_a | op_b;
      AluAdd:                 w_alu_result = op_a + op_b;
      AluSub:                 w_alu_result = op_a - op_b;
      AluSlt:                 w_alu_result = {{(DATA_W-1){1'b0}}, w_slt};
      AluNor:                 w_alu_result = ~(op_a | op_b);
      AluXor:                 w_alu_result = op_a ^ op_b;
      AluSll, AluSrl, AluSra: w_alu_result = w_shift_load;
      default:                w_alu_result = op_a + op_b;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state; DONE with a new acceptance restarts directly
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle: begin
        if (w_accept) w_state_next = w_go_shift ? StShift : StDone;
      end
      StShift: begin
        if (w_shift_last) w_state_next = StDone;
      end
      StDone: begin
        if (w_accept)       w_state_next = w_go_shift ? StShift : StDone;
        else if (out_ready) w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // FSM outputs: handshakes decoded from state; nothing is accepted while in reset
  always_comb begin
    in_ready  = !reset && ((r_state == StIdle) || ((r_state == StDone) && out_ready));
    out_valid = (r_state == StDone);
  end

  // Result register: load on acceptance, step while shifting, hold otherwise
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result <= '0;
    end else if (w_accept) begin
      r_result <= w_alu_result;
    end else if (r_state == StShift) begin
      r_result <= w_shift_out;
    end
  end

  assign result = r_result;
  assign zero   = (r_result == '0);

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 SHALL have one clock and an asynchronous, active-high reset: clk  input  1  rising-edge clock; reset  input  1  async active-high reset.
REQ-002 SHALL provide: in_valid  input  1  operation offered.
REQ-003 SHALL provide: in_ready  output  1  unit accepts operation this cycle.
REQ-004 SHALL provide: alu_ctrl  input  5  operation code (AND 00000, OR 00001, ADD 00010, SUB 00110, SLT 00111, NOR 01100, XOR 01101, SLL 10000, SRL 10001, SRA 10010).
REQ-005 SHALL provide: sign  input  1  SLT compare mode, 1 signed, 0 unsigned.
REQ-006 SHALL provide: op_a  input  32  first operand; op_b  input  32  second operand / shift source.
REQ-007 SHALL provide: shamt  input  5  shift amount.
REQ-008 SHALL provide: out_valid  output  1  result available; out_ready  input  1  consumer takes result.
REQ-009 SHALL provide: result  output  32  registered result; zero  output  1  result == 0.

Function
REQ-010 SHALL accept an operation when in_valid && in_ready, capturing alu_ctrl, sign, op_a, op_b, shamt.
REQ-011 SHALL implement FSM IDLE, SHIFT, DONE; IDLE->DONE on accepted non-shift op, IDLE->SHIFT on accepted shift op (REQ-019 only), SHIFT->DONE when remaining count reaches 0, DONE->IDLE on out_ready without new acceptance.
REQ-012 SHALL drive in_ready = (state==IDLE) || (state==DONE && out_ready); in SHIFT in_ready = 0.
REQ-013 SHALL, when DONE && out_ready && in_valid, retire current result and accept the new op the same cycle (back-to-back, one op per cycle for non-shift ops).
REQ-014 SHALL compute: AND/OR/XOR/NOR bitwise; ADD/SUB mod 2^32, no overflow flag; SLT result = 32'd1 if op_a < op_b (signed when sign=1, unsigned when sign=0) else 0.
REQ-015 SHALL shift op_b by shamt: SLL zero-fill left, SRL zero-fill right, SRA replicate op_b[31].
REQ-016 SHALL treat any undefined alu_ctrl code as ADD.
REQ-017 SHALL assert out_valid exactly in DONE, holding result and zero stable until out_ready.
REQ-018 SHALL give latency 1 cycle (acceptance edge to out_valid) for non-shift ops.

Reset
REQ-020 SHALL on reset: state IDLE, out_valid 0, result 0, zero 1, shift counter 0; in_ready 0 while reset high, 1 first cycle after release.
REQ-021 SHALL abandon any in-flight op when reset asserts mid-SHIFT or mid-DONE; no result emitted afterwards.

Configuration
REQ-019 SHALL honour macro ALU_FAST_SHIFT_EN: defined -> single-cycle barrel shift, shifts follow REQ-018, SHIFT state unreachable; undefined -> iterative one bit per cycle, shift latency shamt+1 cycles (shamt 0 goes IDLE->DONE directly, latency 1).

Structure
REQ-022 SHALL place alu_ctrl encodings, FSM state encodings and DATA_W=32 in shared package alu_pkg, also used by the existing ALU control decoder.
REQ-023 SHALL contain one sub-module alu_shifter (barrel or one-bit step per ALU_FAST_SHIFT_EN); all other logic inline.

Verification
REQ-024 ADD op_a=0x7FFFFFFF op_b=1 -> out_valid next cycle, result 0x80000000, zero 0.
REQ-025 SLT op_a=0xFFFFFFFF op_b=1: sign=1 -> result 1; sign=0 -> result 0.
REQ-026 SRA op_b=0x80000000 shamt=31 -> result 0xFFFFFFFF; latency 32 cycles without ALU_FAST_SHIFT_EN, 1 with.
REQ-027 out_ready held 0 for 5 cycles after SUB 5-5 -> result 0, zero 1 held stable, in_ready 0; then out_ready=1 with in_valid=1 -> new op accepted same cycle.
REQ-028 reset asserted during SLL shamt=20 at cycle 10 -> out_valid stays 0, result 0, in_ready 1 after release.
REQ-029 alu_ctrl=5'b11111 op_a=3 op_b=4 -> result 7.
